// File: rtl/nvdla_noc_rd_wrr_arb.sv
// NOC read-request ingress: weighted round-robin arbitration across clients with an
// outstanding-beat limit. Winners are issued on a registered AXI AR channel; arid
// carries the winning client index. Egress beat pulses return outstanding credit.
module nvdla_noc_rd_wrr_arb #(
  parameter int NUM_CLIENTS = 8,
  parameter int CIDX_W      = $clog2(NUM_CLIENTS),
  parameter int ADDR_W      = 64,
  parameter int LEN_W       = 4,
  parameter int ID_W        = 8,
  parameter int OS_W        = 9
) (
  input  logic                          nvdla_core_clk,
  input  logic                          nvdla_core_rst,
  input  logic [NUM_CLIENTS-1:0]        req_valid,
  output logic [NUM_CLIENTS-1:0]        req_ready,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] req_addr,
  input  logic [NUM_CLIENTS*LEN_W-1:0]  req_len,
  input  logic [NUM_CLIENTS*8-1:0]      reg2dp_rd_weight,
  input  logic [7:0]                    reg2dp_rd_os_cnt,
  input  logic                          eg2ig_axi_vld,
  output logic                          ar_arvalid,
  input  logic                          ar_arready,
  output logic [ID_W-1:0]               ar_arid,
  output logic [LEN_W-1:0]              ar_arlen,
  output logic [ADDR_W-1:0]             ar_araddr,
  output logic [OS_W-1:0]               os_cnt
);

  // Credit holds weight+1 (up to 256), so it needs one bit more than the weight.
  localparam int CRD_W = 9;

  // Per-client views of the flat client buses.
  logic [NUM_CLIENTS-1:0][ADDR_W-1:0] addr_a;
  logic [NUM_CLIENTS-1:0][LEN_W-1:0]  len_a;
  logic [NUM_CLIENTS-1:0][7:0]        wgt_a;
  assign addr_a = req_addr;
  assign len_a  = req_len;
  assign wgt_a  = reg2dp_rd_weight;

  logic [NUM_CLIENTS-1:0][CRD_W-1:0] credit_q, credit_d, credit_eff;
  logic [CIDX_W-1:0]                 rr_ptr_q, rr_ptr_d;
  logic                              ar_arvalid_q, ar_arvalid_d;
  logic [ID_W-1:0]                   ar_arid_q, ar_arid_d;
  logic [LEN_W-1:0]                  ar_arlen_q, ar_arlen_d;
  logic [ADDR_W-1:0]                 ar_araddr_q, ar_araddr_d;
  logic [OS_W-1:0]                   os_cnt_q, os_cnt_d;

  logic [NUM_CLIENTS-1:0] crd_nz, elig;
  logic                   need_reload, slot_free, found, grant;
  logic [CIDX_W-1:0]      gidx;
  logic [OS_W:0]          need, cap, os_sum;
  int                     j;

  // Eligibility (with same-cycle credit reload) and rotating first-eligible pick.
  always_comb begin
    crd_nz      = '0;
    elig        = '0;
    credit_eff  = credit_q;
    found       = 1'b0;
    gidx        = '0;
    need        = '0;
    j           = 0;
    cap         = (OS_W+1)'(reg2dp_rd_os_cnt) + (OS_W+1)'(1);
    for (int i = 0; i < NUM_CLIENTS; i++)
      crd_nz[i] = (credit_q[i] != '0);
    // Reload is judged only among clients currently requesting.
    need_reload = ~|(req_valid & crd_nz);
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      if (need_reload)
        credit_eff[i] = CRD_W'(wgt_a[i]) + CRD_W'(1);
      need    = (OS_W+1)'(os_cnt_q) + (OS_W+1)'(len_a[i]) + (OS_W+1)'(1);
      elig[i] = req_valid[i] && (credit_eff[i] != '0) && (need <= cap);
    end
    for (int k = 0; k < NUM_CLIENTS; k++) begin
      j = int'(rr_ptr_q) + k;
      if (j >= NUM_CLIENTS)
        j = j - NUM_CLIENTS;
      if (!found && elig[j]) begin
        found = 1'b1;
        gidx  = CIDX_W'(j);
      end
    end
    slot_free = !ar_arvalid_q || ar_arready;
    grant     = found && slot_free && !nvdla_core_rst;
    req_ready = grant ? (NUM_CLIENTS'(1) << gidx) : '0;
  end

  // Next-state: credits, pointer, AR output slot and outstanding-beat count.
  always_comb begin
    credit_d     = credit_eff;
    rr_ptr_d     = rr_ptr_q;
    ar_arvalid_d = ar_arvalid_q && !ar_arready;
    ar_arid_d    = ar_arid_q;
    ar_arlen_d   = ar_arlen_q;
    ar_araddr_d  = ar_araddr_q;
    os_sum       = (OS_W+1)'(os_cnt_q);
    if (grant) begin
      credit_d[gidx] = credit_eff[gidx] - CRD_W'(1);
      rr_ptr_d       = (gidx == CIDX_W'(NUM_CLIENTS-1)) ? '0 : gidx + CIDX_W'(1);
      ar_arvalid_d   = 1'b1;
      ar_arid_d      = ID_W'(gidx);
      ar_arlen_d     = len_a[gidx];
      ar_araddr_d    = addr_a[gidx];
      os_sum         = os_sum + (OS_W+1)'(len_a[gidx]) + (OS_W+1)'(1);
    end
    // Beat return at zero outstanding is illegal; hold zero rather than wrap.
    if (eg2ig_axi_vld && (os_sum != '0))
      os_sum = os_sum - (OS_W+1)'(1);
    os_cnt_d = os_sum[OS_W-1:0];
  end

  // State registers with synchronous active-high reset.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      credit_q     <= '0;
      rr_ptr_q     <= '0;
      ar_arvalid_q <= 1'b0;
      ar_arid_q    <= '0;
      ar_arlen_q   <= '0;
      ar_araddr_q  <= '0;
      os_cnt_q     <= '0;
    end else begin
      credit_q     <= credit_d;
      rr_ptr_q     <= rr_ptr_d;
      ar_arvalid_q <= ar_arvalid_d;
      ar_arid_q    <= ar_arid_d;
      ar_arlen_q   <= ar_arlen_d;
      ar_araddr_q  <= ar_araddr_d;
      os_cnt_q     <= os_cnt_d;
    end
  end

  // Flags a returned beat with nothing outstanding and nothing granted.
  always_ff @(posedge nvdla_core_clk) begin
    if (!nvdla_core_rst)
      assert (!(eg2ig_axi_vld && (os_cnt_q == '0) && !grant));
  end

  assign ar_arvalid = ar_arvalid_q;
  assign ar_arid    = ar_arid_q;
  assign ar_arlen   = ar_arlen_q;
  assign ar_araddr  = ar_araddr_q;
  assign os_cnt     = os_cnt_q;

endmodule

// File: tb/tb_nvdla_noc_rd_wrr_arb.sv
// Bench for nvdla_noc_rd_wrr_arb: a per-cycle reference model predicts grants and
// outstanding beats; predicted AR beats are queued and checked by an AR monitor.
module tb_nvdla_noc_rd_wrr_arb;
  localparam int N = 8;
  localparam int AW = 64;
  localparam int LW = 4;
  localparam int IW = 8;
  localparam int OW = 9;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*AW-1:0]   req_addr;
  logic [N*LW-1:0]   req_len;
  logic [N*8-1:0]    weight;
  logic [7:0]        limit;
  logic              eg;
  logic              ar_arvalid, ar_arready;
  logic [IW-1:0]     ar_arid;
  logic [LW-1:0]     ar_arlen;
  logic [AW-1:0]     ar_araddr;
  logic [OW-1:0]     os_cnt;

  nvdla_noc_rd_wrr_arb dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
    .reg2dp_rd_weight(weight), .reg2dp_rd_os_cnt(limit), .eg2ig_axi_vld(eg),
    .ar_arvalid(ar_arvalid), .ar_arready(ar_arready), .ar_arid(ar_arid),
    .ar_arlen(ar_arlen), .ar_araddr(ar_araddr), .os_cnt(os_cnt));

  always #5 clk = ~clk;

  typedef struct { int id; int len; logic [AW-1:0] addr; } exp_t;
  exp_t exp_q[$];

  int nchk = 0, nfail = 0;

  // stimulus knobs
  int            s_v[N], s_len[N], s_w[N];
  logic [AW-1:0] s_addr[N];
  int            s_lim;
  bit            s_eg, s_rdy;
  // reference model state
  int m_cr[N], m_rr, m_os, m_g;
  bit m_slot;
  // monitor statistics
  int hs_cnt, hs_id[N];

  task automatic chk(input string nm, input longint act, input longint req);
    nchk++;
    if (act != req) begin
      nfail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic clr_stats();
    hs_cnt = 0;
    for (int i = 0; i < N; i++) hs_id[i] = 0;
  endtask

  // One clock: drive knobs, predict and check the combinational accept, advance model.
  task automatic step(input bit do_rst);
    int cr_e[N];
    bit any;
    for (int i = 0; i < N; i++) begin
      req_valid[i] = s_v[i][0];
      req_len[i*LW +: LW] = LW'(s_len[i]);
      req_addr[i*AW +: AW] = s_addr[i];
      weight[i*8 +: 8] = 8'(s_w[i]);
    end
    limit = 8'(s_lim); eg = s_eg; ar_arready = s_rdy; rst = do_rst;
    #1;
    m_g = -1;
    if (do_rst) begin
      chk("rst_req_ready", req_ready, 0);
    end else begin
      any = 0;
      for (int i = 0; i < N; i++) if (s_v[i] != 0 && m_cr[i] != 0) any = 1;
      for (int i = 0; i < N; i++) cr_e[i] = any ? m_cr[i] : s_w[i] + 1;
      if (!m_slot || s_rdy)
        for (int k = 0; k < N; k++) begin
          int i;
          i = (m_rr + k) % N;
          if (m_g < 0 && s_v[i] != 0 && cr_e[i] > 0 && m_os + s_len[i] + 1 <= s_lim + 1) m_g = i;
        end
      chk("req_ready", req_ready, (m_g >= 0) ? (1 << m_g) : 0);
      for (int i = 0; i < N; i++) m_cr[i] = cr_e[i];
      if (m_g >= 0) begin
        exp_t e;
        e.id = m_g; e.len = s_len[m_g]; e.addr = s_addr[m_g];
        exp_q.push_back(e);
        m_cr[m_g]--;
        m_rr = (m_g + 1) % N;
        m_os += s_len[m_g] + 1;
        m_slot = 1;
      end else if (s_rdy) m_slot = 0;
      if (s_eg && m_os > 0) m_os--;
    end
    @(posedge clk); #1;
    if (do_rst) begin
      for (int i = 0; i < N; i++) m_cr[i] = 0;
      m_rr = 0; m_os = 0; m_slot = 0;
      exp_q.delete();
      chk("rst_arvalid", ar_arvalid, 0);
      chk("rst_os_cnt", os_cnt, 0);
    end else begin
      chk("os_cnt", os_cnt, m_os);
      chk("ar_arvalid", ar_arvalid, m_slot);
    end
  endtask

  task automatic idle_knobs();
    for (int i = 0; i < N; i++) begin
      s_v[i] = 0; s_len[i] = 0; s_w[i] = 0; s_addr[i] = 64'(i) << 12;
    end
    s_lim = 255; s_eg = 0; s_rdy = 1;
  endtask

  task automatic do_reset();
    step(1); step(1);
  endtask

  // AR monitor: pops expected beats on handshake, checks hold during backpressure.
  bit            stall_prev = 0;
  logic [IW-1:0] h_id;
  logic [LW-1:0] h_len;
  logic [AW-1:0] h_addr;
  always @(negedge clk) begin
    if (rst) stall_prev = 0;
    else begin
      if (stall_prev) begin
        chk("hold_arvalid", ar_arvalid, 1);
        chk("hold_fields", {ar_arid, ar_arlen, ar_araddr} == {h_id, h_len, h_addr}, 1);
      end
      stall_prev = ar_arvalid && !ar_arready;
      h_id = ar_arid; h_len = ar_arlen; h_addr = ar_araddr;
      if (ar_arvalid && ar_arready) begin
        hs_cnt++;
        if (ar_arid < N) hs_id[ar_arid]++;
        if (exp_q.size() == 0) chk("ar_unexpected", 1, 0);
        else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("arid", ar_arid, e.id);
          chk("arlen", ar_arlen, e.len);
          chk("araddr", ar_araddr == e.addr, 1);
        end
      end
    end
  end

  initial begin
    int g_last;
    rst = 1; req_valid = '0; req_addr = '0; req_len = '0; weight = '0; limit = '0;
    eg = 0; ar_arready = 0;
    idle_knobs();

    // reset with every client requesting
    for (int i = 0; i < N; i++) s_v[i] = 1;
    do_reset();

    // WRR w0=2, w1=0 -> three grants to client 0 per one to client 1
    idle_knobs();
    s_v[0] = 1; s_v[1] = 1; s_w[0] = 2; s_w[1] = 0;
    do_reset(); clr_stats();
    for (int c = 0; c < 13; c++) step(0);
    chk("wrr_hs_per_clk", hs_cnt, 12);
    chk("wrr_id1_count", hs_id[1], 3);
    chk("wrr_id0_count", hs_id[0], 9);

    // outstanding limit: 7 -> two 4-beat bursts then stall until 4 beats return
    idle_knobs();
    s_lim = 7; s_v[0] = 1; s_len[0] = 3; s_w[0] = 255;
    do_reset(); clr_stats();
    for (int c = 0; c < 10; c++) step(0);
    chk("os_stall_hs", hs_cnt, 2);
    chk("os_stall_cnt", os_cnt, 8);
    s_eg = 1;
    for (int c = 0; c < 4; c++) step(0);
    s_eg = 0;
    step(0); step(0);
    chk("os_resume_hs", hs_cnt, 3);

    // backpressure: slot held for 5 clocks, then handshake with same-cycle regrant
    idle_knobs();
    s_v[0] = 1; s_len[0] = 2; s_w[0] = 255; s_addr[0] = 64'hdead_beef_0000_1000;
    do_reset(); clr_stats();
    s_rdy = 0;
    for (int c = 0; c < 6; c++) step(0);
    chk("bp_no_hs", hs_cnt, 0);
    s_rdy = 1;
    step(0);
    step(0);
    chk("bp_hs", hs_cnt, 2);

    // bypass: oversized burst on client 0 never blocks client 1
    idle_knobs();
    s_lim = 3; s_v[0] = 1; s_len[0] = 7; s_v[1] = 1; s_len[1] = 0;
    do_reset(); clr_stats();
    for (int c = 0; c < 20; c++) begin
      s_eg = (m_os > 0) && ($urandom_range(1) == 1);
      step(0);
      chk("bypass_os_le4", os_cnt <= 4, 1);
    end
    chk("bypass_id0", hs_id[0], 0);
    chk("bypass_id1_some", hs_id[1] > 0, 1);

    // simultaneous inc/dec at os_cnt=5
    idle_knobs();
    do_reset();
    s_v[0] = 1; s_len[0] = 4;
    step(0);
    chk("incdec_pre", os_cnt, 5);
    s_len[0] = 1; s_eg = 1;
    step(0);
    chk("incdec_post", os_cnt, 6);
    s_v[0] = 0; s_eg = 0;
    step(0);

    // randomized traffic with weight/limit changes
    idle_knobs();
    do_reset();
    g_last = -1;
    for (int c = 0; c < 3000; c++) begin
      if (c % 250 == 0) begin
        s_lim = (c % 500 == 0) ? $urandom_range(255) : $urandom_range(40, 255);
        for (int i = 0; i < N; i++) s_w[i] = $urandom_range(3);
      end
      for (int i = 0; i < N; i++)
        if (s_v[i] == 0 || g_last == i) begin
          s_v[i] = $urandom_range(1);
          s_len[i] = $urandom_range(15);
          s_addr[i] = {$urandom, $urandom};
        end
      s_rdy = ($urandom_range(3) != 0);
      s_eg = (m_os > 0) && ($urandom_range(1) == 1);
      step(0);
      g_last = m_g;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
    $finish;
  end

endmodule
